gb_serial: RTL and testbench

Link-port serial controller for the Game Boy core. It implements the SB (0xFF01) and SC (0xFF02) registers and shifts one byte out and one byte in per transfer, using either the internal 8192 Hz shift clock or an external one. On completion it pulses the serial interrupt, which drives the interrupt-flag register bit 3. It replaces the constant SB/SC read values in the top-level CPU read mux.

---
 rtl/gb_serial.sv | 99 +++++++++
 tb/tb_gb_serial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gb_serial.sv
// gb_serial: link-port SB/SC registers with internal or external shift clock.
// Shifts one byte MSB-first per transfer and pulses irq when the byte completes.
module gb_serial #(
    parameter int HALF_PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_sel_sb,
    input  logic       cpu_sel_sc,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       irq,
    output logic       ser_clk_out,
    input  logic       ser_clk_in,
    output logic       ser_data_out,
    input  logic       ser_data_in
);
    localparam int DW = $clog2(HALF_PERIOD);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q;
    logic [7:0]    sb_q;
    logic          sc_start_q;
    logic          sc_int_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_cnt_q;
    logic          clk_out_q;
    logic          data_out_q;
    logic          irq_q;
    logic [2:0]    cin_q;
    logic [1:0]    din_q;

    logic wr_sb, wr_sc, int_run, wrap, ext_rise, ext_fall, fall, rise, done;

    // cin_q[1] is the synchronised pin; cin_q[2] holds its previous value for edge detection
    assign wr_sb    = cpu_wr && cpu_sel_sb;
    assign wr_sc    = cpu_wr && cpu_sel_sc;
    assign int_run  = state_q == ACTIVE && sc_int_q;
    assign wrap     = int_run && div_q == DW'(HALF_PERIOD - 1);
    assign ext_rise = state_q == ACTIVE && !sc_int_q && cin_q[1] && !cin_q[2];
    assign ext_fall = state_q == ACTIVE && !sc_int_q && !cin_q[1] && cin_q[2];
    assign fall     = (wrap && clk_out_q) || ext_fall;
    assign rise     = (wrap && !clk_out_q) || ext_rise;
    assign done     = rise && bit_cnt_q == 3'd7;

    assign cpu_do       = cpu_sel_sb ? sb_q : cpu_sel_sc ? {sc_start_q, 6'h3F, sc_int_q} : 8'hFF;
    assign irq          = irq_q;
    assign ser_clk_out  = clk_out_q;
    assign ser_data_out = data_out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sb_q       <= 8'h00;
            sc_start_q <= 1'b0;
            sc_int_q   <= 1'b0;
            div_q      <= '0;
            bit_cnt_q  <= 3'd0;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
            irq_q      <= 1'b0;
            cin_q      <= 3'b111;
            din_q      <= 2'b11;
        end else begin
            cin_q <= {cin_q[1:0], ser_clk_in};
            din_q <= {din_q[0], ser_data_in};
            irq_q <= done;
            if (int_run)
                div_q <= wrap ? '0 : div_q + DW'(1);
            if (wrap)
                clk_out_q <= !clk_out_q;
            if (fall)
                data_out_q <= sb_q[7];
            if (rise) begin
                sb_q      <= {sb_q[6:0], din_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (done) begin
                state_q    <= IDLE;
                sc_start_q <= 1'b0;
            end
            // CPU writes override any shift or completion update in the same cycle
            if (wr_sb)
                sb_q <= cpu_di;
            if (wr_sc) begin
                sc_start_q <= cpu_di[7];
                sc_int_q   <= cpu_di[0];
                state_q    <= cpu_di[7] ? ACTIVE : IDLE;
                clk_out_q  <= 1'b1;
                if (cpu_di[7]) begin
                    div_q     <= '0;
                    bit_cnt_q <= 3'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gb_serial.sv
// tb_gb_serial: directed checks of gb_serial with HALF_PERIOD=4.
// Cycle indices count posedges; outputs are sampled on negedges.
module tb_gb_serial;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_sel_sb = 1'b0;
    logic       cpu_sel_sc = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [7:0] cpu_di = 8'h00;
    logic [7:0] cpu_do;
    logic       irq;
    logic       ser_clk_out;
    logic       sci = 1'b1;
    logic       ser_data_out;
    logic       loop = 1'b0;
    logic       din = 1'b1;
    logic       sdi;

    assign sdi = loop ? ser_data_out : din;

    gb_serial #(.HALF_PERIOD(HP)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_sel_sb(cpu_sel_sb), .cpu_sel_sc(cpu_sel_sc),
        .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .irq(irq),
        .ser_clk_out(ser_clk_out), .ser_clk_in(sci), .ser_data_out(ser_data_out),
        .ser_data_in(sdi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pulses = 0;
    int         low_cnt = 0;
    int         irq_cnt = 0;
    logic [7:0] dseq = 8'h00;
    logic       prev_clk = 1'b1;
    always @(negedge clk) begin
        if (prev_clk && !ser_clk_out) begin
            pulses = pulses + 1;
            dseq = {dseq[6:0], ser_data_out};
        end
        prev_clk = ser_clk_out;
        if (!ser_clk_out) low_cnt = low_cnt + 1;
        if (irq) irq_cnt = irq_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a write for one cycle; t is the index of the posedge that registers it
    task automatic cpu_write(input logic sc, input logic [7:0] d, output int t);
        @(negedge clk);
        cpu_sel_sb = !sc;
        cpu_sel_sc = sc;
        cpu_di = d;
        cpu_wr = 1'b1;
        @(negedge clk);
        t = cyc;
        cpu_wr = 1'b0;
        cpu_sel_sb = 1'b0;
        cpu_sel_sc = 1'b0;
    endtask

    task automatic rd(input logic sc, output logic [7:0] v);
        cpu_sel_sb = !sc;
        cpu_sel_sc = sc;
        #1;
        v = cpu_do;
        cpu_sel_sb = 1'b0;
        cpu_sel_sc = 1'b0;
    endtask

    // at = index of the posedge after which irq is first seen high, -1 on timeout
    task automatic wait_irq(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] pat;
        int t, t2, at, pe, base_p, base_i, base_l;

        repeat (3) @(negedge clk);
        rd(1'b1, v); check("reset_sc", v, 8'h7E);
        rd(1'b0, v); check("reset_sb", v, 8'h00);
        check("reset_clk_out", ser_clk_out, 1);
        check("reset_data_out", ser_data_out, 1);
        check("reset_irq", irq, 0);
        reset_n = 1'b1;

        // internal loopback transfer of 0xA5
        loop = 1'b1;
        cpu_write(1'b0, 8'hA5, t);
        base_p = pulses; base_i = irq_cnt;
        cpu_write(1'b1, 8'h81, t);
        wait_irq(200, at);
        check("loop_irq_lat", at - t, 16 * HP);
        @(negedge clk);
        check("loop_irq_low", irq, 0);
        repeat (3) @(negedge clk);
        check("loop_pulses", pulses - base_p, 8);
        check("loop_dseq", dseq, 8'hA5);
        check("loop_irq_cnt", irq_cnt - base_i, 1);
        rd(1'b0, v); check("loop_sb", v, 8'hA5);
        rd(1'b1, v); check("loop_sc", v, 8'h7F);
        check("loop_clk_idle", ser_clk_out, 1);

        // unconnected input fills with ones
        loop = 1'b0; din = 1'b1;
        cpu_write(1'b0, 8'h3C, t);
        base_i = irq_cnt;
        cpu_write(1'b1, 8'h81, t);
        wait_irq(200, at);
        check("nc_irq_lat", at - t, 16 * HP);
        repeat (3) @(negedge clk);
        rd(1'b0, v); check("nc_sb", v, 8'hFF);
        check("nc_irq_cnt", irq_cnt - base_i, 1);

        // external clock transfer, data 1,1,0,0,1,0,1,0
        cpu_write(1'b0, 8'h00, t);
        cpu_write(1'b1, 8'h80, t);
        base_l = low_cnt; base_i = irq_cnt;
        pat = 8'b11001010;
        pe = 0;
        for (int i = 0; i < 8; i++) begin
            sci = 1'b0; din = pat[7-i];
            repeat (5) @(negedge clk);
            sci = 1'b1; pe = cyc;
            if (i < 7) repeat (5) @(negedge clk);
        end
        wait_irq(20, at);
        check("ext_irq_lat", at - pe, 3);
        repeat (3) @(negedge clk);
        rd(1'b0, v); check("ext_sb", v, 8'hCA);
        rd(1'b1, v); check("ext_sc", v, 8'h7E);
        check("ext_irq_cnt", irq_cnt - base_i, 1);
        check("ext_clk_out_low", low_cnt - base_l, 0);
        din = 1'b1;

        // abort after 3 bits (3rd rising edge at t+6*HP)
        cpu_write(1'b1, 8'h81, t);
        while (cyc < t + 6 * HP + 1) @(negedge clk);
        base_i = irq_cnt;
        cpu_write(1'b1, 8'h01, t2);
        base_l = low_cnt;
        repeat (20 * HP) @(negedge clk);
        check("abort_irq_cnt", irq_cnt - base_i, 0);
        check("abort_clk_low", low_cnt - base_l, 0);
        check("abort_clk_out", ser_clk_out, 1);
        rd(1'b1, v); check("abort_sc", v, 8'h7F);

        // restart mid-transfer
        base_i = irq_cnt;
        cpu_write(1'b1, 8'h81, t);
        while (cyc < t + 30) @(negedge clk);
        cpu_write(1'b1, 8'h81, t2);
        wait_irq(200, at);
        check("restart_irq_lat", at - t2, 16 * HP);
        repeat (3) @(negedge clk);
        check("restart_irq_cnt", irq_cnt - base_i, 1);

        // SB write landing on the first rising shift edge (t+2*HP)
        cpu_write(1'b1, 8'h81, t);
        while (cyc < t + 2 * HP - 2) @(negedge clk);
        cpu_write(1'b0, 8'h5A, t2);
        check("coll_edge", t2 - t, 2 * HP);
        rd(1'b0, v); check("coll_sb", v, 8'h5A);

        // async reset after the falling edge that drives sb[7]=0 out
        while (cyc < t + 3 * HP + 2) @(negedge clk);
        check("pre_reset_data_out", ser_data_out, 0);
        base_i = irq_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("rst_clk_out", ser_clk_out, 1);
        check("rst_data_out", ser_data_out, 1);
        check("rst_irq", irq, 0);
        rd(1'b1, v); check("rst_sc", v, 8'h7E);
        rd(1'b0, v); check("rst_sb", v, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20 * HP) @(negedge clk);
        check("rst_irq_cnt", irq_cnt - base_i, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
